// File: rtl/serial_cmd_initiator.sv
`default_nettype none
// =============================================================================
// serial_cmd_initiator
// Sends an opcode plus argument bytes through a UART transmitter, then gathers
// the fixed-length response into a 136-byte buffer readable as 32-bit words.
// Rev 1.0
// =============================================================================
module serial_cmd_initiator #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [47:0] cmd_args,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_len,
    output logic        rsp_timeout,
    output logic        err_opcode,
    input  logic [5:0]  rd_word_addr,
    output logic [31:0] rd_word
);

    localparam int                 TIMER_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 2);
    localparam int                 MEM_BYTES  = 136;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_SENT = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [2:0] arg_count(input logic [2:0] op);
        case (op)
            3'd1, 3'd3, 3'd5, 3'd7: arg_count = 3'd1;
            3'd2:                   arg_count = 3'd6;
            default:                arg_count = 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] rsp_bytes(input logic [2:0] op);
        case (op)
            3'd0:    rsp_bytes = 8'd1;
            3'd4:    rsp_bytes = 8'd136;
            default: rsp_bytes = 8'd0;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [7:0]           opcode_q, opcode_d;
    logic [47:0]          args_q, args_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           count_q, count_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [7:0]           rsp_len_q, rsp_len_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 err_opcode_q, err_opcode_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic [31:0]          rd_word_q, rd_word_d;

    logic [7:0]           rsp_mem [0:MEM_BYTES-1];
    logic                 mem_we;
    logic [7:0]           tx_byte;
    logic [2:0]           n_args;
    logic [7:0]           n_rsp;
    logic [7:0]           count_inc;
    logic                 accept;
    logic                 opcode_ok;
    logic [7:0]           rd_base;

    assign accept    = cmd_valid & cmd_ready_q;
    assign opcode_ok = (cmd_opcode[7:3] == 5'd0);
    assign n_args    = arg_count(opcode_q[2:0]);
    assign n_rsp     = rsp_bytes(opcode_q[2:0]);
    assign count_inc = count_q + 8'd1;

    // Wire byte 0 is the opcode, byte k (k >= 1) is argument k-1.
    always_comb begin
        case (idx_q)
            3'd1:    tx_byte = args_q[7:0];
            3'd2:    tx_byte = args_q[15:8];
            3'd3:    tx_byte = args_q[23:16];
            3'd4:    tx_byte = args_q[31:24];
            3'd5:    tx_byte = args_q[39:32];
            3'd6:    tx_byte = args_q[47:40];
            default: tx_byte = opcode_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        args_d        = args_q;
        idx_d         = idx_q;
        count_d       = count_q;
        timer_d       = timer_q;
        rsp_len_d     = rsp_len_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_valid_d   = 1'b0;
        err_opcode_d  = 1'b0;
        mem_we        = 1'b0;
        tx_start      = 1'b0;
        tx_data       = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (opcode_ok) begin
                        opcode_d      = cmd_opcode;
                        args_d        = cmd_args;
                        idx_d         = 3'd0;
                        count_d       = 8'd0;
                        rsp_timeout_d = 1'b0;
                        state_d       = ST_SEND;
                    end else begin
                        err_opcode_d  = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    tx_data  = tx_byte;
                    state_d  = ST_SENT;
                end
            end
            ST_SENT: begin
                if (idx_q < n_args) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_SEND;
                end else if (n_rsp == 8'd0) begin
                    state_d = ST_DONE;
                end else begin
                    timer_d = '0;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (rx_ready) begin
                    mem_we  = 1'b1;
                    count_d = count_inc;
                    timer_d = '0;
                    if (count_inc == n_rsp)
                        state_d = ST_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_DONE: begin
                rsp_valid_d = 1'b1;
                rsp_len_d   = count_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is held low for the cycle that shows rsp_valid and while in reset.
    assign cmd_ready_d = (state_d == ST_IDLE) && (state_q != ST_DONE);

    always_comb begin
        rd_base   = {rd_word_addr, 2'b00};
        rd_word_d = 32'h0;
        if (rd_word_addr < 6'd34)
            rd_word_d = {rsp_mem[rd_base + 8'd3], rsp_mem[rd_base + 8'd2],
                         rsp_mem[rd_base + 8'd1], rsp_mem[rd_base]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            opcode_q      <= 8'h00;
            args_q        <= 48'h0;
            idx_q         <= 3'd0;
            count_q       <= 8'd0;
            timer_q       <= '0;
            rsp_len_q     <= 8'd0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            err_opcode_q  <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rd_word_q     <= 32'h0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            args_q        <= args_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            rsp_len_q     <= rsp_len_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_valid_q   <= rsp_valid_d;
            err_opcode_q  <= err_opcode_d;
            cmd_ready_q   <= cmd_ready_d;
            rd_word_q     <= rd_word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            rsp_mem[count_q] <= rx_data;
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_len     = rsp_len_q;
    assign rsp_timeout = rsp_timeout_q;
    assign err_opcode  = err_opcode_q;
    assign rd_word     = rd_word_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_cmd_initiator.sv
`default_nettype none
// =============================================================================
// tb_serial_cmd_initiator
// Scoreboard bench: expected tx bytes / responses queued at issue, popped by a monitor.
// Rev 1.0
// =============================================================================
module tb_serial_cmd_initiator;

    localparam int TO = 100;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [47:0] cmd_args;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rsp_valid;
    logic [7:0]  rsp_len;
    logic        rsp_timeout;
    logic        err_opcode;
    logic [5:0]  rd_word_addr;
    logic [31:0] rd_word;

    serial_cmd_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_args     (cmd_args),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rsp_valid    (rsp_valid),
        .rsp_len      (rsp_len),
        .rsp_timeout  (rsp_timeout),
        .err_opcode   (err_opcode),
        .rd_word_addr (rd_word_addr),
        .rd_word      (rd_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int len;
        int to;
        int cyc;
    } rsp_t;

    int         ARGS_T [8] = '{0, 1, 6, 1, 0, 1, 0, 1};
    int         RSP_T  [8] = '{1, 0, 0, 0, 136, 0, 0, 0};

    logic [7:0] tx_q [$];
    rsp_t       rsp_q [$];
    int         err_exp     = 0;
    int         rsp_seen    = 0;
    int         last_tx_cyc = 0;
    int         last_rx_cyc = 0;
    int         acc_cyc     = 0;
    int         busy_hold   = 1;
    int         n_tests     = 0;
    int         n_fail      = 0;
    logic [7:0] mbuf   [136];
    bit         mknown [136];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT output event consumes one scoreboard entry.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (tx_start) begin
                    last_tx_cyc = cyc;
                    chk("tx_busy_at_strobe", tx_busy, 0);
                    chk("tx_strobe_expected", tx_q.size() > 0, 1);
                    if (tx_q.size() > 0)
                        chk("tx_data", tx_data, tx_q.pop_front());
                end
                if (rsp_valid) begin
                    rsp_seen++;
                    chk("rsp_expected", rsp_q.size() > 0, 1);
                    if (rsp_q.size() > 0) begin
                        e = rsp_q.pop_front();
                        chk("rsp_len", rsp_len, e.len);
                        chk("rsp_timeout", rsp_timeout, e.to);
                        if (e.cyc >= 0)
                            chk("rsp_latency_cycle", cyc, e.cyc);
                    end
                end
                if (err_opcode) begin
                    chk("err_expected", err_exp > 0, 1);
                    if (err_exp > 0) err_exp--;
                end
            end
        end
    end

    // UART transmitter model: busy rises the cycle after the strobe and stays for busy_hold cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && tx_start) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (busy_hold) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_ready    = 1'b1;
        rx_data     = b;
        last_rx_cyc = cyc;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [47:0] args);
        bit got;
        got = 1'b0;
        if (op < 8) begin
            tx_q.push_back(op);
            for (int k = 0; k < ARGS_T[op[2:0]]; k++)
                tx_q.push_back(args[8*k +: 8]);
        end else begin
            err_exp++;
        end
        @(posedge clk);
        #1;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_args   = args;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        acc_cyc = cyc;
        chk("cmd_accept", got, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_tx_done();
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            #1;
            if (tx_q.size() == 0) break;
        end
        chk("tx_bytes_outstanding", tx_q.size(), 0);
    endtask

    task automatic wait_rsp();
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            #1;
            if (rsp_q.size() == 0) break;
        end
        chk("rsp_outstanding", rsp_q.size(), 0);
    endtask

    task automatic read_word(input int a, output logic [31:0] w);
        @(posedge clk);
        #1 rd_word_addr = a[5:0];
        @(posedge clk);
        @(negedge clk);
        w = rd_word;
    endtask

    task automatic check_buffer();
        logic [31:0] w;
        for (int a = 0; a < 34; a++) begin
            if (mknown[4*a] && mknown[4*a+1] && mknown[4*a+2] && mknown[4*a+3]) begin
                read_word(a, w);
                chk($sformatf("rd_word[%0d]", a), w,
                    {mbuf[4*a+3], mbuf[4*a+2], mbuf[4*a+1], mbuf[4*a]});
            end
        end
    endtask

    // mode: 0 random rx bytes, 1 byte i = i & 0xFF, 2 constant 0x17
    task automatic run_cmd(input logic [7:0] op, input logic [47:0] args, input int mode);
        int         n;
        logic [7:0] b;
        rsp_t       e;
        issue(op, args);
        if (op >= 8) begin
            repeat (3) @(posedge clk);
            #1 chk("err_pulses_outstanding", err_exp, 0);
        end else begin
            wait_tx_done();
            n = RSP_T[op[2:0]];
            if (n == 0) begin
                e.len = 0; e.to = 0; e.cyc = last_tx_cyc + 3;
                rsp_q.push_back(e);
            end else begin
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    b = (mode == 1) ? i[7:0] : (mode == 2) ? 8'h17 : 8'($urandom);
                    mbuf[i]   = b;
                    mknown[i] = 1'b1;
                    send_rx(b);
                end
                e.len = n; e.to = 0; e.cyc = last_rx_cyc + 2;
                rsp_q.push_back(e);
            end
            wait_rsp();
            check_buffer();
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  b;
        rsp_t        e;
        int          c;
        int          saved;

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 8'h00; cmd_args = 48'h0;
        rx_ready = 1'b0; rx_data = 8'h00; rd_word_addr = 6'd0;
        for (int i = 0; i < 136; i++) begin mknown[i] = 1'b0; mbuf[i] = 8'h00; end

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_tx_start", tx_start, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_len", rsp_len, 0);
        chk("reset_rsp_timeout", rsp_timeout, 0);
        chk("reset_err_opcode", err_opcode, 0);
        chk("reset_rd_word", rd_word, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // VERSION
        run_cmd(8'h00, 48'h0, 2);
        chk("tx_first_latency", last_tx_cyc, acc_cyc + 1);
        read_word(0, w);
        chk("version_byte", w[7:0], 8'h17);

        // SET_PLL with a slow transmitter
        busy_hold = 3;
        run_cmd(8'h02, 48'h060504030201, 0);
        busy_hold = 1;

        // SEND_HISTOGRAM with an index pattern, then a stray byte in IDLE
        run_cmd(8'h04, 48'h0, 1);
        read_word(0, w);
        chk("histogram_word0", w, 32'h03020100);
        read_word(33, w);
        chk("histogram_word33", w, 32'h87868584);
        send_rx(8'hEE);
        repeat (3) @(posedge clk);
        check_buffer();

        // Timeout with no response byte
        issue(8'h00, 48'h0);
        wait_tx_done();
        e.len = 0; e.to = 1; e.cyc = last_tx_cyc + 1 + TO + 1;
        rsp_q.push_back(e);
        wait_rsp();

        // Response byte on the expiry cycle is stored instead of timing out
        issue(8'h00, 48'h0);
        wait_tx_done();
        c = last_tx_cyc + 1 + TO - 1;
        for (int k = 0; k < 4 * TO; k++) begin
            @(posedge clk);
            #1;
            if (cyc >= c) break;
        end
        rx_ready = 1'b1; rx_data = 8'hA5; last_rx_cyc = cyc;
        mbuf[0] = 8'hA5; mknown[0] = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        e.len = 1; e.to = 0; e.cyc = last_rx_cyc + 2;
        rsp_q.push_back(e);
        wait_rsp();
        check_buffer();

        // Randomized traffic
        for (int t = 0; t < 20; t++) begin
            busy_hold = $urandom_range(1, 4);
            run_cmd(8'($urandom_range(0, 9)), {16'($urandom), 32'($urandom)}, 0);
        end
        busy_hold = 1;

        // Bad opcode
        issue(8'h09, 48'h0);
        @(negedge clk);
        chk("ready_after_bad_opcode", cmd_ready, 1);
        repeat (3) @(posedge clk);
        #1 chk("err_pulses_outstanding", err_exp, 0);

        // Reset in the middle of a histogram response
        issue(8'h04, 48'h0);
        wait_tx_done();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            mbuf[i] = b; mknown[i] = 1'b1;
            send_rx(b);
        end
        saved = rsp_seen;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_reset_cmd_ready", cmd_ready, 0);
        chk("mid_reset_tx_start", tx_start, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("no_rsp_after_reset", rsp_seen, saved);
        chk("ready_after_mid_reset", cmd_ready, 1);
        check_buffer();

        // Recovery
        run_cmd(8'h00, 48'h0, 0);
        run_cmd(8'h07, {16'($urandom), 32'($urandom)}, 0);

        chk("scoreboard_leftover", tx_q.size() + rsp_q.size() + err_exp, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
